mult_pipe_gen: RTL and testbench

MULT_PIPE_GEN -- requirements
Module: mult_pipe_gen

---
 rtl/mult_pipe_gen.sv | 158 +++++++++++++++
 tb/tb_mult_pipe_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_gen.sv
// Iterative-chunk pipelined multiplier: each stage folds WIDTH/NUM_STAGES multiplier bits into a 2*WIDTH sum.
// Define MULT_BMASK_SQUASH_EN to enable branch-mask squash/clear; otherwise br_* is ignored and bmask passes through.
module mult_pipe_gen #(
  parameter int WIDTH      = 64,
  parameter int NUM_STAGES = 8,
  parameter int TAG_W      = 7,
  parameter int PAYLOAD_W  = 96,
  parameter int BMASK_W    = 4,
  localparam int IDX_W     = (BMASK_W > 1) ? $clog2(BMASK_W) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [1:0]           mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [BMASK_W-1:0]   in_bmask,
  input  logic                 br_valid,
  input  logic [IDX_W-1:0]     br_idx,
  input  logic                 br_mispredict,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     product,
  output logic [TAG_W-1:0]     out_tag,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [BMASK_W-1:0]   out_bmask
);

  localparam int CH = WIDTH / NUM_STAGES;
  localparam int PW = 2 * WIDTH;
  localparam int LS = NUM_STAGES - 1;

  // Handshake: an op moves between stages only when advance is high; in_ready is advance.
  logic advance;

  logic                 v_q       [NUM_STAGES];
  logic [PW-1:0]        acc_q     [NUM_STAGES];
  logic [1:0]           mode_q    [NUM_STAGES];
  logic [TAG_W-1:0]     tag_q     [NUM_STAGES];
  logic [PAYLOAD_W-1:0] payload_q [NUM_STAGES];
  logic [BMASK_W-1:0]   bmask_q   [NUM_STAGES];
  logic [WIDTH-1:0]     a_q       [NUM_STAGES-1];
  logic [WIDTH-1:0]     b_q       [NUM_STAGES-1];

  logic                 src_v       [NUM_STAGES];
  logic [WIDTH-1:0]     src_a       [NUM_STAGES];
  logic [WIDTH-1:0]     src_b       [NUM_STAGES];
  logic [PW-1:0]        src_acc     [NUM_STAGES];
  logic [1:0]           src_mode    [NUM_STAGES];
  logic [TAG_W-1:0]     src_tag     [NUM_STAGES];
  logic [PAYLOAD_W-1:0] src_payload [NUM_STAGES];
  logic [BMASK_W-1:0]   src_bmask   [NUM_STAGES];
  logic [PW-1:0]        nxt_acc     [NUM_STAGES];

  logic [NUM_STAGES-1:0] kill;
  logic                  kill_in;
  logic [BMASK_W-1:0]    clr_mask;

`ifdef MULT_BMASK_SQUASH_EN
  assign kill_in  = br_valid && br_mispredict && in_bmask[br_idx];
  assign clr_mask = (br_valid && !br_mispredict) ? (BMASK_W'(1) << br_idx) : '0;
`else
  logic unused_br;
  assign unused_br = ^{br_valid, br_idx, br_mispredict};
  assign kill_in   = 1'b0;
  assign clr_mask  = '0;
`endif

  assign out_valid = v_q[LS] && !kill[LS];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign src_v[s]       = in_valid && !kill_in;
      assign src_a[s]       = mcand;
      assign src_b[s]       = mplier;
      assign src_acc[s]     = '0;
      assign src_mode[s]    = mode;
      assign src_tag[s]     = in_tag;
      assign src_payload[s] = in_payload;
      assign src_bmask[s]   = in_bmask;
    end else begin : g_body
      assign src_v[s]       = v_q[s-1] && !kill[s-1];
      assign src_a[s]       = a_q[s-1];
      assign src_b[s]       = b_q[s-1];
      assign src_acc[s]     = acc_q[s-1];
      assign src_mode[s]    = mode_q[s-1];
      assign src_tag[s]     = tag_q[s-1];
      assign src_payload[s] = payload_q[s-1];
      assign src_bmask[s]   = bmask_q[s-1];
    end

`ifdef MULT_BMASK_SQUASH_EN
    assign kill[s] = br_valid && br_mispredict && bmask_q[s][br_idx];
`else
    assign kill[s] = 1'b0;
`endif

    logic [PW-1:0] part;
    logic [PW-1:0] sum;
    assign part = (PW'(src_a[s]) * PW'(src_b[s][s*CH +: CH])) << (s * CH);
    assign sum  = src_acc[s] + part;

    // Unsigned product minus the two's-complement weight of each signed operand's sign bit.
    if (s == LS) begin : g_fix
      logic [PW-1:0] fix_a;
      logic [PW-1:0] fix_b;
      assign fix_a = (src_mode[s][1] && src_a[s][WIDTH-1]) ? {src_b[s], {WIDTH{1'b0}}} : '0;
      assign fix_b = (src_mode[s] == 2'b10 && src_b[s][WIDTH-1]) ? {src_a[s], {WIDTH{1'b0}}} : '0;
      assign nxt_acc[s] = sum - fix_a - fix_b;
    end else begin : g_nofix
      assign nxt_acc[s] = sum;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        v_q[s]       <= 1'b0;
        acc_q[s]     <= '0;
        mode_q[s]    <= '0;
        tag_q[s]     <= '0;
        payload_q[s] <= '0;
        bmask_q[s]   <= '0;
      end else if (advance) begin
        v_q[s]       <= src_v[s];
        acc_q[s]     <= nxt_acc[s];
        mode_q[s]    <= src_mode[s];
        tag_q[s]     <= src_tag[s];
        payload_q[s] <= src_payload[s];
        bmask_q[s]   <= src_bmask[s] & ~clr_mask;
      end else begin
        v_q[s]       <= v_q[s] && !kill[s];
        bmask_q[s]   <= bmask_q[s] & ~clr_mask;
      end
    end

    if (s < LS) begin : g_ops
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end else if (advance) begin
          a_q[s] <= src_a[s];
          b_q[s] <= src_b[s];
        end
      end
    end
  end

  assign product     = (mode_q[LS] == 2'b00) ? acc_q[LS][WIDTH-1:0] : acc_q[LS][PW-1:WIDTH];
  assign out_tag     = tag_q[LS];
  assign out_payload = payload_q[LS];
  assign out_bmask   = bmask_q[LS] & ~clr_mask;

endmodule

// File: tb/tb_mult_pipe_gen.sv
// Directed bench for mult_pipe_gen: driver tasks push expected results into queues, a negedge monitor pops and compares.
module tb_mult_pipe_gen;
  localparam int W   = 64;
  localparam int NS  = 8;
  localparam int TW  = 7;
  localparam int PLW = 96;
  localparam int BW  = 4;
`ifdef MULT_BMASK_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [W-1:0]   mcand, mplier;
  logic [1:0]     mode;
  logic [TW-1:0]  in_tag;
  logic [PLW-1:0] in_payload;
  logic [BW-1:0]  in_bmask;
  logic           br_valid;
  logic [1:0]     br_idx;
  logic           br_mispredict;
  logic           out_valid, out_ready;
  logic [W-1:0]   product;
  logic [TW-1:0]  out_tag;
  logic [PLW-1:0] out_payload;
  logic [BW-1:0]  out_bmask;

  mult_pipe_gen dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mcand(mcand), .mplier(mplier), .mode(mode), .in_tag(in_tag),
    .in_payload(in_payload), .in_bmask(in_bmask), .br_valid(br_valid),
    .br_idx(br_idx), .br_mispredict(br_mispredict), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .out_tag(out_tag),
    .out_payload(out_payload), .out_bmask(out_bmask)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0]   exp_q[$];
  logic [TW-1:0]  exp_tag_q[$];
  logic [PLW-1:0] exp_pl_q[$];
  logic [BW-1:0]  exp_bm_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_seen   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [PLW-1:0] mk_pl(input logic [TW-1:0] t, input logic [W-1:0] a);
    return {25'h155_5555, t, a};
  endfunction

  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d product %0h, required no output", out_tag, product);
      end else begin
        check("product", product, exp_q.pop_front());
        check("out_tag", out_tag, exp_tag_q.pop_front());
        check("out_payload", out_payload, exp_pl_q.pop_front());
        check("out_bmask", out_bmask, exp_bm_q.pop_front());
      end
    end
  end

  // driver tasks (inputs change at posedge+1, DUT sampled at negedge)
  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input logic [TW-1:0] tag,
                       input logic [BW-1:0] bm, input logic [BW-1:0] exp_bm, input bit keep);
    int guard = 0;
    in_valid = 1'b1; mode = m; mcand = a; mplier = b;
    in_tag = tag; in_payload = mk_pl(tag, a); in_bmask = bm;
    @(negedge clock);
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout tag %0d: in_ready stuck at 0, required 1", tag);
    end else if (keep) begin
      exp_q.push_back(exp);
      exp_tag_q.push_back(tag);
      exp_pl_q.push_back(mk_pl(tag, a));
      exp_bm_q.push_back(exp_bm);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic branch_cycle(input bit mispredict, input logic [TW-1:0] tag,
                              input logic [BW-1:0] bm, input logic [BW-1:0] exp_bm, input bit keep);
    in_valid = 1'b1; mode = 2'b00; mcand = 64'd8; mplier = 64'd9;
    in_tag = tag; in_payload = mk_pl(tag, 64'd8); in_bmask = bm;
    br_valid = 1'b1; br_idx = 2'd0; br_mispredict = mispredict;
    @(negedge clock);
    check("branch_cycle_in_ready", in_ready, 1);
    if (keep) begin
      exp_q.push_back(64'd72);
      exp_tag_q.push_back(tag);
      exp_pl_q.push_back(mk_pl(tag, 64'd8));
      exp_bm_q.push_back(exp_bm);
    end
    @(posedge clock); #1;
    br_valid = 1'b0; br_mispredict = 1'b0; in_valid = 1'b0;
  endtask

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;

  initial begin
    int lat;
    bit found;
    int base;
    int g;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mcand = '0; mplier = '0; mode = '0; in_tag = '0; in_payload = '0; in_bmask = '0;
    br_valid = 1'b0; br_idx = '0; br_mispredict = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_product", product, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_out_payload", out_payload, 0);
    check("reset_out_bmask", out_bmask, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // first-op latency
    issue(2'b00, 64'd3, 64'd5, 64'd15, 7'd1, 4'b0000, 4'b0000, 1'b1);
    in_valid = 1'b0;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    check("latency", lat, NS);
    @(posedge clock); #1;

    // signedness modes and operand boundaries, back to back
    issue(2'b10, ONES, ONES, 64'd0, 7'd2, 4'b0100, 4'b0100, 1'b1);
    issue(2'b01, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 7'd3, 4'b1000, 4'b1000, 1'b1);
    issue(2'b11, ONES, ONES, ONES, 7'd4, 4'b0000, 4'b0000, 1'b1);
    issue(2'b10, M3, 64'd5, ONES, 7'd5, 4'b0000, 4'b0000, 1'b1);
    issue(2'b00, M3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 7'd6, 4'b0000, 4'b0000, 1'b1);
    issue(2'b01, MSB, 64'd4, 64'd2, 7'd7, 4'b0000, 4'b0000, 1'b1);
    issue(2'b10, MSB, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 7'd8, 4'b0000, 4'b0000, 1'b1);
    issue(2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 7'd9, 4'b0000, 4'b0000, 1'b1);
    issue(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 7'd10, 4'b0000, 4'b0000, 1'b1);
    issue(2'b11, 64'd2, ONES, 64'd1, 7'd11, 4'b0000, 4'b0000, 1'b1);
    issue(2'b10, 64'd2, ONES, ONES, 7'd12, 4'b0000, 4'b0000, 1'b1);
    idle(20);

    // back-to-back stream with a 5-cycle output stall
    base = n_seen;
    fork
      begin
        for (int i = 1; i <= 8; i++)
          issue(2'b00, W'(i), W'(i), W'(i * i), TW'(20 + i), 4'b0000, 4'b0000, 1'b1);
        in_valid = 1'b0;
      end
      begin
        g = 0;
        while (n_seen < base + 3 && g < 200) begin
          @(negedge clock);
          g++;
        end
        if (g >= 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL stall_wait: got %0d outputs, required 3", n_seen - base);
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          check("stall_out_valid", out_valid, 1);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    idle(20);

    // mispredict on bit 0 with three ops in flight plus one offered the same cycle
    issue(2'b00, 64'd2, 64'd3, 64'd6, 7'd40, 4'b0001, 4'b0001, !SQ);
    issue(2'b00, 64'd4, 64'd5, 64'd20, 7'd41, 4'b0010, 4'b0010, 1'b1);
    issue(2'b00, 64'd6, 64'd7, 64'd42, 7'd42, 4'b0001, 4'b0001, !SQ);
    branch_cycle(1'b1, 7'd43, 4'b0001, 4'b0001, !SQ);
    idle(20);

    // correct prediction on bit 0: everything survives, bit 0 cleared
    issue(2'b00, 64'd2, 64'd3, 64'd6, 7'd44, 4'b0001, SQ ? 4'b0000 : 4'b0001, 1'b1);
    issue(2'b00, 64'd4, 64'd5, 64'd20, 7'd45, 4'b0010, 4'b0010, 1'b1);
    issue(2'b00, 64'd6, 64'd7, 64'd42, 7'd46, 4'b0001, SQ ? 4'b0000 : 4'b0001, 1'b1);
    branch_cycle(1'b0, 7'd47, 4'b0011, SQ ? 4'b0010 : 4'b0011, 1'b1);
    idle(20);

    // reset with four ops in flight, then one op after release
    out_ready = 1'b0;
    issue(2'b00, 64'd1, 64'd2, 64'd2, 7'd60, 4'b0000, 4'b0000, 1'b0);
    issue(2'b00, 64'd3, 64'd4, 64'd12, 7'd61, 4'b0000, 4'b0000, 1'b0);
    issue(2'b00, 64'd5, 64'd6, 64'd30, 7'd62, 4'b0000, 4'b0000, 1'b0);
    issue(2'b00, 64'd7, 64'd8, 64'd56, 7'd63, 4'b0000, 4'b0000, 1'b0);
    idle(5);
    check("pre_reset_out_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_product", product, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    issue(2'b00, 64'd7, 64'd6, 64'd42, 7'd50, 4'b0000, 4'b0000, 1'b1);
    idle(20);

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clock);
      g++;
    end
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
